// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts a command byte out on device-generated clock falls and checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       bit_idx, bit_idx_next;
  logic [9:0]       frame, frame_next;
  logic             acked, acked_next;
  logic             clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic             fall, accept;
  logic             tx_ready_next, busy_next, done_next, ack_err_next, timeout_err_next;
  logic             clk_oe_next, data_oe_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall   = clk_prev & ~clk_s2;
  assign accept = tx_valid & tx_ready;

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    bit_idx_next     = bit_idx;
    frame_next       = frame;
    acked_next       = acked;
    clk_oe_next      = ps2_clk_oe;
    data_oe_next     = ps2_data_oe;
    done_next        = 1'b0;
    ack_err_next     = 1'b0;
    timeout_err_next = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          frame_next   = {1'b1, ~^tx_data, tx_data};
          cnt_next     = '0;
          clk_oe_next  = 1'b1;
          data_oe_next = 1'b0;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_next     = '0;
          data_oe_next = 1'b1;
          state_next   = REQ;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      REQ: begin
        clk_oe_next  = 1'b0;
        bit_idx_next = '0;
        cnt_next     = '0;
        state_next   = SHIFT;
      end
      SHIFT, ACK, WAIT_IDLE: begin
        // Timeout wins over every other event in the device-clocked phase.
        if (cnt == TO_LAST) begin
          clk_oe_next      = 1'b0;
          data_oe_next     = 1'b0;
          timeout_err_next = 1'b1;
          cnt_next         = '0;
          state_next       = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
          if (state == SHIFT) begin
            if (fall) begin
              data_oe_next = ~frame[bit_idx];
              bit_idx_next = bit_idx + 1'b1;
              if (bit_idx == 4'd9) state_next = ACK;
            end
          end else if (state == ACK) begin
            if (fall) begin
              acked_next = ~data_s2;
              state_next = WAIT_IDLE;
            end
          end else begin
            if (clk_s2 && data_s2) begin
              done_next    = acked;
              ack_err_next = ~acked;
              cnt_next     = '0;
              state_next   = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    tx_ready_next = (state_next == IDLE);
    busy_next     = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      acked       <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      frame       <= frame_next;
      acked       <= acked_next;
      tx_ready    <= tx_ready_next;
      busy        <= busy_next;
      done        <= done_next;
      ack_err     <= ack_err_next;
      timeout_err <= timeout_err_next;
      ps2_clk_oe  <= clk_oe_next;
      ps2_data_oe <= data_oe_next;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out and
// scoreboards check every sampled bit and every completion pulse.
module tb_ps2_host_tx;

  localparam int INHIBIT = 8;
  localparam int TIMEOUT = 400;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, ack_err, timeout_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int timeout_cyc = 0;
  int release_cyc = 0;
  int mon_got, mon_exp;

  bit exp_bits[$];
  int exp_outcome[$];

  // Open-collector pads: either side may pull low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .done(done), .ack_err(ack_err),
    .timeout_err(timeout_err), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Completion monitor: 0 = done, 1 = ack_err, 2 = timeout_err.
  always @(negedge clock) begin
    if (reset && (done || ack_err || timeout_err)) begin
      checks++;
      mon_got = done ? 0 : (ack_err ? 1 : 2);
      if ((int'(done) + int'(ack_err) + int'(timeout_err)) != 1 || exp_outcome.size() == 0) begin
        errors++;
        $display("[TB] FAIL outcome: done=%0b ack_err=%0b timeout_err=%0b, expected queue depth %0d",
                 done, ack_err, timeout_err, exp_outcome.size());
      end else begin
        mon_exp = exp_outcome.pop_front();
        if (mon_got != mon_exp) begin
          errors++;
          $display("[TB] FAIL outcome: got kind %0d, expected kind %0d", mon_got, mon_exp);
        end
      end
      if (timeout_err) timeout_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (!tx_ready && g < 2000) begin @(negedge clock); g++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_ready: tx_ready=%b, required 1", tx_ready);
    end
    @(posedge clock); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
    @(posedge clock); #1;
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  // Device side: waits for the request-to-send, then generates n_falls clock pulses.
  task automatic device_xfer(input int n_falls, input bit give_ack, input bit check_inhibit);
    int g = 0;
    int inh_len = 0;
    int req_len = 0;
    bit e;
    @(negedge clock);
    while (!ps2_clk_oe && g < 100) begin @(negedge clock); g++; end
    while (ps2_clk_oe && !ps2_data_oe && g < 100) begin inh_len++; @(negedge clock); g++; end
    while (ps2_clk_oe && ps2_data_oe && g < 100) begin req_len++; @(negedge clock); g++; end
    release_cyc = cyc;
    if (check_inhibit) begin
      checks++;
      if (inh_len != INHIBIT) begin
        errors++;
        $display("[TB] FAIL inhibit_len: got %0d cycles, required %0d", inh_len, INHIBIT);
      end
      checks++;
      if (req_len != 1) begin
        errors++;
        $display("[TB] FAIL req_len: got %0d cycles, required 1", req_len);
      end
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_bit: clk_oe=%b data=%b, required clk_oe=0 data=0", ps2_clk_oe, ps2_data_in);
    end
    for (int f = 1; f <= n_falls; f++) begin
      @(posedge clock); #1;
      dev_clk = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      if (f <= 10) begin
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("[TB] FAIL frame_bit%0d: no expected bit queued", f);
        end else begin
          e = exp_bits.pop_front();
          if (ps2_data_in !== e) begin
            errors++;
            $display("[TB] FAIL frame_bit%0d: data=%b, required %b", f, ps2_data_in, e);
          end
        end
      end
      dev_clk = 1'b1;
      if (f == 10 && give_ack) dev_data = 1'b0;
      if (f == 11) dev_data = 1'b1;
      repeat (9) @(posedge clock);
    end
  endtask

  task automatic wait_outcome(input string name);
    int g = 0;
    while (exp_outcome.size() != 0 && g < 1000) begin @(negedge clock); g++; end
    @(negedge clock);
    checks++;
    if (exp_outcome.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: no completion pulse, %0d outcome(s) pending", name, exp_outcome.size());
      exp_outcome.delete();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle: ready=%b busy=%b clk_oe=%b data_oe=%b, required 1 0 0 0",
               name, tx_ready, busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: ready=%b busy=%b clk_oe=%b data_oe=%b", tx_ready, busy, ps2_clk_oe, ps2_data_oe);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 ||
        done !== 1'b0 || ack_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%b busy=%b clk_oe=%b data_oe=%b pulses=%b%b%b",
               tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err);
    end
  endtask

  task automatic test_send_ack(input logic [7:0] b);
    exp_outcome.push_back(0);
    send_byte(b);
    device_xfer(11, 1'b1, 1'b1);
    wait_outcome($sformatf("ack_%02h", b));
  endtask

  task automatic test_busy_ignored();
    exp_outcome.push_back(0);
    send_byte(8'h00);
    @(posedge clock); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(negedge clock);
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_hold: ready=%b busy=%b, required 0 1", tx_ready, busy);
    end
    @(posedge clock); #1;
    tx_valid = 1'b0;
    device_xfer(11, 1'b1, 1'b0);
    wait_outcome("ack_00");
  endtask

  task automatic test_no_ack();
    exp_outcome.push_back(1);
    send_byte(8'hFF);
    device_xfer(11, 1'b0, 1'b1);
    wait_outcome("noack_ff");
  endtask

  task automatic test_timeout();
    exp_outcome.push_back(2);
    send_byte(8'hF4);
    device_xfer(4, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stalled_bit3: data_oe=%b, required 1", ps2_data_oe);
    end
    wait_outcome("timeout_f4");
    checks++;
    if (timeout_cyc - release_cyc != TIMEOUT) begin
      errors++;
      $display("[TB] FAIL timeout_delay: got %0d cycles, required %0d", timeout_cyc - release_cyc, TIMEOUT);
    end
    exp_bits.delete();
  endtask

  task automatic test_reset_mid_transfer();
    exp_outcome.push_back(0);
    send_byte(8'hF4);
    device_xfer(4, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: data_oe=%b busy=%b, required 1 1", ps2_data_oe, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: clk_oe=%b data_oe=%b busy=%b ready=%b, required 0 0 0 1",
               ps2_clk_oe, ps2_data_oe, busy, tx_ready);
    end
    exp_outcome.delete();
    exp_bits.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    test_send_ack(8'hED);
  endtask

  initial begin
    $display("[TB] ps2_host_tx bench start");
    test_reset();
    test_send_ack(8'hED);
    test_send_ack(8'h07);
    test_busy_ignored();
    test_no_ack();
    test_timeout();
    test_reset_mid_transfer();
    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
